// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - host/pad side signal bundle of the UART transmitter
interface uart_transmitter_if;
    logic       tx_clk_en;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overrun;
    logic       tx_overrun_clr;
    logic       tx;

    modport master (
        output tx_clk_en, tx_data, tx_wr, tx_overrun_clr,
        input  tx_full, tx_empty, tx_busy, tx_done, tx_overrun, tx
    );

    modport slave (
        input  tx_clk_en, tx_data, tx_wr, tx_overrun_clr,
        output tx_full, tx_empty, tx_busy, tx_done, tx_overrun, tx
    );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter: byte FIFO feeding a tick-driven start/data/parity/stop framer
module uart_transmitter #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SAMPLE_TIMES = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    uart_transmitter_if.slave  bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (SAMPLE_TIMES > 1) ? $clog2(SAMPLE_TIMES) : 1;
    localparam int BW = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head_data;
    logic                 head_parity;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 last_tick;

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign push        = bus.tx_wr && !fifo_full;
    assign head_data   = fifo_q[rd_ptr_q];
    assign head_parity = (PARITY == 1) ? ~(^head_data) : (^head_data);
    assign last_tick   = (tick_q == TW'(SAMPLE_TIMES - 1));

    // Storage needs no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.tx_data[DATA_BITS-1:0];
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (bus.tx_overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (bus.tx_wr && fifo_full) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        if (bus.tx_clk_en) begin
            tick_d = last_tick ? '0 : tick_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    tx_d   = 1'b1;
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = head_data;
                        parity_d = head_parity;
                        tx_d     = 1'b0;
                        state_d  = S_START;
                    end
                end
                S_START: begin
                    if (last_tick) begin
                        tx_d    = shift_q[0];
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (last_tick) begin
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_d = '0;
                            if (PARITY != 0) begin
                                tx_d    = parity_q;
                                state_d = S_PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (last_tick) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (last_tick) begin
                        if (bit_q == BW'(STOP_BITS - 1)) begin
                            done_d = 1'b1;
                            // Chain straight into the next start bit when more data is waiting.
                            if (!fifo_empty) begin
                                pop      = 1'b1;
                                shift_d  = head_data;
                                parity_d = head_parity;
                                tick_d   = '0;
                                tx_d     = 1'b0;
                                state_d  = S_START;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
                default: begin
                    tick_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_busy    = (state_q != S_IDLE);
    assign bus.tx_done    = done_q;
    assign bus.tx_full    = fifo_full;
    assign bus.tx_empty   = fifo_empty;
    assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - three framing configurations driven in parallel against a tick-level line model
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       wr  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    int         en_mode = 1;
    int         en_phase = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    // Instance 0: 8N1/16x/depth4, 1: 8E1/16x/depth4, 2: 7O2/8x/depth2
    int c_db  [3] = '{8, 8, 7};
    int c_par [3] = '{0, 2, 1};
    int c_stop[3] = '{1, 1, 2};
    int c_st  [3] = '{16, 16, 8};
    int c_dep [3] = '{4, 4, 2};

    uart_transmitter_if if_a ();
    uart_transmitter_if if_b ();
    uart_transmitter_if if_c ();

    assign if_a.tx_clk_en = en;  assign if_a.tx_data = din;  assign if_a.tx_wr = wr;  assign if_a.tx_overrun_clr = clr;
    assign if_b.tx_clk_en = en;  assign if_b.tx_data = din;  assign if_b.tx_wr = wr;  assign if_b.tx_overrun_clr = clr;
    assign if_c.tx_clk_en = en;  assign if_c.tx_data = din;  assign if_c.tx_wr = wr;  assign if_c.tx_overrun_clr = clr;

    uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SAMPLE_TIMES(16), .FIFO_DEPTH(4))
        dut_a (.sys_clk(clk), .rst(rst), .bus(if_a));
    uart_transmitter #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SAMPLE_TIMES(16), .FIFO_DEPTH(4))
        dut_b (.sys_clk(clk), .rst(rst), .bus(if_b));
    uart_transmitter #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SAMPLE_TIMES(8), .FIFO_DEPTH(2))
        dut_c (.sys_clk(clk), .rst(rst), .bus(if_c));

    logic [2:0] tx_w, busy_w, done_w, full_w, empty_w, ovr_w;
    assign tx_w    = {if_c.tx,         if_b.tx,         if_a.tx};
    assign busy_w  = {if_c.tx_busy,    if_b.tx_busy,    if_a.tx_busy};
    assign done_w  = {if_c.tx_done,    if_b.tx_done,    if_a.tx_done};
    assign full_w  = {if_c.tx_full,    if_b.tx_full,    if_a.tx_full};
    assign empty_w = {if_c.tx_empty,   if_b.tx_empty,   if_a.tx_empty};
    assign ovr_w   = {if_c.tx_overrun, if_b.tx_overrun, if_a.tx_overrun};

    // Reference model: pending-byte queue plus "ticks since the frame's start bit began"
    logic [7:0] mq [3][$];
    logic [7:0] cur  [3];
    int         cnt  [3];
    logic       act  [3];
    logic       mdone[3];
    logic       movr [3];

    function automatic int flen(input int i);
        return c_st[i] * (1 + c_db[i] + ((c_par[i] != 0) ? 1 : 0) + c_stop[i]);
    endfunction

    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= c_db[i]) return b[k-1];
        if (c_par[i] != 0 && k == c_db[i] + 1) begin
            ones = 0;
            for (int j = 0; j < c_db[i]; j++) ones += int'(b[j]);
            return (c_par[i] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int i);
        return act[i] ? exp_bit(i, cur[i], cnt[i] / c_st[i]) : 1'b1;
    endfunction

    function automatic logic model_idle();
        for (int i = 0; i < 3; i++) begin
            if (act[i] || mq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        logic full_pre, empty_pre;
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    mq[i].delete();
                    act[i] = 1'b0; cnt[i] = 0; mdone[i] = 1'b0; movr[i] = 1'b0; cur[i] = 8'h00;
                end else begin
                    full_pre  = (mq[i].size() == c_dep[i]);
                    empty_pre = (mq[i].size() == 0);
                    mdone[i]  = 1'b0;
                    if (en) begin
                        if (act[i]) begin
                            cnt[i]++;
                            if (cnt[i] == flen(i)) begin
                                act[i] = 1'b0;
                                mdone[i] = 1'b1;
                            end
                        end
                        if (!act[i] && !empty_pre) begin
                            cur[i] = mq[i].pop_front();
                            act[i] = 1'b1;
                            cnt[i] = 0;
                        end
                    end
                    if (wr && !full_pre) mq[i].push_back(din);
                    if (clr) movr[i] = 1'b0;
                    if (wr && full_pre) movr[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int idx, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed %b expected %b at %0t", tag, idx, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("tx",      i, tx_w[i],    exp_tx(i));
                chk("busy",    i, busy_w[i],  act[i]);
                chk("done",    i, done_w[i],  mdone[i]);
                chk("full",    i, full_w[i],  logic'(mq[i].size() == c_dep[i]));
                chk("empty",   i, empty_w[i], logic'(mq[i].size() == 0));
                chk("overrun", i, ovr_w[i],   movr[i]);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (en_mode)
                0: en = 1'b0;
                1: en = 1'b1;
                2: begin
                    en = (en_phase == 0);
                    en_phase = (en_phase + 1) % 3;
                end
                default: en = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick_in(input logic w, input logic [7:0] b, input logic c);
        @(negedge clk);
        wr  = w;
        din = w ? b : 8'($urandom);
        clr = c;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!model_idle() && n < budget) begin
            tick_in(1'b0, 8'h00, 1'b0);
            n++;
        end
        repeat (2) tick_in(1'b0, 8'h00, 1'b0);
        chk_int("drain_within_budget", int'(n < budget), 1);
    endtask

    initial begin
        int n, busy_cnt, done_cnt, low_cnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx",    0, if_a.tx,         1'b1);
        chk("rst_empty", 0, if_a.tx_empty,   1'b1);
        chk("rst_full",  0, if_a.tx_full,    1'b0);
        chk("rst_busy",  0, if_a.tx_busy,    1'b0);
        chk("rst_done",  0, if_a.tx_done,    1'b0);
        chk("rst_ovr",   0, if_a.tx_overrun, 1'b0);
        #1 rst = 1'b0;

        // 8N1 0x55: done pulse visible 162 cycles after the write cycle
        tick_in(1'b1, 8'h55, 1'b0);
        n = 0;
        while (n < 400) begin
            tick_in(1'b0, 8'h00, 1'b0);
            n++;
            if (if_a.tx_done === 1'b1) break;
        end
        chk_int("t1_done_latency", n, 162);
        wait_drain(2000);

        // 0xA3: even parity bit on instance 1, odd parity on instance 2 (7 data bits)
        tick_in(1'b1, 8'hA3, 1'b0);
        for (int k = 1; k <= 154; k++) begin
            tick_in(1'b0, 8'h00, 1'b0);
            if (k == 70)  chk("t2_odd_parity",  2, if_c.tx, 1'b0);
            if (k == 154) chk("t2_even_parity", 1, if_b.tx, 1'b0);
        end
        wait_drain(2000);

        // back-to-back frames: 320 contiguous busy cycles and two done pulses
        tick_in(1'b1, 8'h11, 1'b0);
        tick_in(1'b1, 8'h22, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            tick_in(1'b0, 8'h00, 1'b0);
            busy_cnt += int'(if_a.tx_busy);
            done_cnt += int'(if_a.tx_done);
        end
        chk_int("t3_busy_cycles", busy_cnt, 320);
        chk_int("t3_done_pulses", done_cnt, 2);
        wait_drain(2000);

        // fill while ticks are stopped, overrun, set-wins, clear
        en_mode = 0;
        repeat (2) tick_in(1'b0, 8'h00, 1'b0);
        tick_in(1'b1, 8'hC1, 1'b0);
        tick_in(1'b1, 8'hC2, 1'b0);
        tick_in(1'b1, 8'hC3, 1'b0);
        tick_in(1'b1, 8'hC4, 1'b0);
        tick_in(1'b0, 8'h00, 1'b0);
        chk("t4_full",     0, if_a.tx_full,    1'b1);
        chk("t4_ovr_pre",  0, if_a.tx_overrun, 1'b0);
        tick_in(1'b1, 8'hEE, 1'b0);
        tick_in(1'b0, 8'h00, 1'b0);
        chk("t4_ovr_set",  0, if_a.tx_overrun, 1'b1);
        tick_in(1'b0, 8'h00, 1'b1);
        tick_in(1'b0, 8'h00, 1'b0);
        chk("t4_ovr_clr",  0, if_a.tx_overrun, 1'b0);
        tick_in(1'b1, 8'h77, 1'b1);
        tick_in(1'b0, 8'h00, 1'b0);
        chk("t4_set_wins", 0, if_a.tx_overrun, 1'b1);
        tick_in(1'b0, 8'h00, 1'b1);
        en_mode = 1;
        wait_drain(3000);

        // one tick in three: busy spans 160 ticks x 3 cycles
        en_mode = 2;
        tick_in(1'b1, 8'h0F, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            tick_in(1'b0, 8'h00, 1'b0);
            busy_cnt += int'(if_a.tx_busy);
        end
        chk_int("t5_busy_cycles", busy_cnt, 480);
        wait_drain(3000);

        // random writes, clears and tick density
        en_mode = 3;
        for (int k = 0; k < 1500; k++) begin
            tick_in(logic'($urandom_range(0, 9) == 0), 8'($urandom), logic'($urandom_range(0, 30) == 0));
        end
        wait_drain(8000);

        // reset mid-DATA with a byte still queued
        en_mode = 1;
        tick_in(1'b1, 8'hAA, 1'b0);
        tick_in(1'b1, 8'hBB, 1'b0);
        repeat (40) tick_in(1'b0, 8'h00, 1'b0);
        chk("t6_busy_pre", 0, if_a.tx_busy, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_tx",    0, if_a.tx,       1'b1);
        chk("t6_rst_empty", 0, if_a.tx_empty, 1'b1);
        chk("t6_rst_busy",  0, if_a.tx_busy,  1'b0);
        chk("t6_rst_tx_b",  1, if_b.tx,       1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            tick_in(1'b0, 8'h00, 1'b0);
            low_cnt += int'(if_a.tx !== 1'b1);
        end
        chk_int("t6_line_quiet", low_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
